// File: rtl/instr_fetch_if.sv
// instr_fetch_if
//   Bundles the fetch unit's PC, memory and decoder handshakes.
//   master : the fetch unit (instr_fetch).
//   slave  : the surrounding PC / memory / decoder environment.
//   Signals:
//     rdy_in              global ready; low freezes the fetch unit
//     pc_to_if_en_in      pc_in is valid for fetch
//     pc_in               fetch address
//     if_to_pc_en_out     one-cycle pulse: advance PC by 4
//     if_to_mem_en_out    memory fetch request valid (one cycle)
//     if_to_mem_addr_out  memory fetch address
//     mem_to_if_en_in     memory returns an instruction this cycle
//     mem_to_if_instr_in  returned instruction
//     flush_in            redirect: discard all fetched state
//     if_to_dec_en_out    queue head valid
//     if_to_dec_instr_out queue head instruction
//     if_to_dec_pc_out    queue head PC
//     dec_to_if_rdy_in    decoder accepts the head this cycle
interface instr_fetch_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);
  logic               rdy_in;
  logic               pc_to_if_en_in;
  logic [ADDR_W-1:0]  pc_in;
  logic               if_to_pc_en_out;
  logic               if_to_mem_en_out;
  logic [ADDR_W-1:0]  if_to_mem_addr_out;
  logic               mem_to_if_en_in;
  logic [INSTR_W-1:0] mem_to_if_instr_in;
  logic               flush_in;
  logic               if_to_dec_en_out;
  logic [INSTR_W-1:0] if_to_dec_instr_out;
  logic [ADDR_W-1:0]  if_to_dec_pc_out;
  logic               dec_to_if_rdy_in;

  modport master (
    input  rdy_in, pc_to_if_en_in, pc_in, mem_to_if_en_in, mem_to_if_instr_in,
           flush_in, dec_to_if_rdy_in,
    output if_to_pc_en_out, if_to_mem_en_out, if_to_mem_addr_out,
           if_to_dec_en_out, if_to_dec_instr_out, if_to_dec_pc_out
  );

  modport slave (
    output rdy_in, pc_to_if_en_in, pc_in, mem_to_if_en_in, mem_to_if_instr_in,
           flush_in, dec_to_if_rdy_in,
    input  if_to_pc_en_out, if_to_mem_en_out, if_to_mem_addr_out,
           if_to_dec_en_out, if_to_dec_instr_out, if_to_dec_pc_out
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch
//   Instruction fetch unit: issues one memory request at a time for the
//   current PC, queues returned {instr, pc} pairs in an IQ_DEPTH-entry FIFO
//   and presents the head to the decoder. A flush empties the queue and, if a
//   request is still in flight, drains (discards) its response.
//   Ports:
//     clk_in  clock, all state on posedge
//     rst_in  synchronous active-high reset (wins over rdy)
//     bus     instr_fetch_if.master (PC, memory and decoder handshakes)
module instr_fetch #(
  parameter int ADDR_W   = 32,
  parameter int INSTR_W  = 32,
  parameter int IQ_DEPTH = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  instr_fetch_if.master bus
);
  localparam int PTR_W = $clog2(IQ_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = 1;
  localparam logic [PTR_W:0]   CNT_ONE   = 1;
  localparam logic [PTR_W:0]   CNT_DEPTH = IQ_DEPTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_e;

  state_e             state_q, state_d;
  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               mem_en_q, mem_en_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
  logic               pc_en_q, pc_en_d;
  logic               push, pop;

  logic [INSTR_W-1:0] iq_instr_q [IQ_DEPTH];
  logic [ADDR_W-1:0]  iq_pc_q    [IQ_DEPTH];

  always_comb begin
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    mem_addr_d = mem_addr_q;
    req_pc_d   = req_pc_q;
    mem_en_d   = 1'b0;
    pc_en_d    = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;

    if (bus.rdy_in) begin
      pop = (count_q != '0) && bus.dec_to_if_rdy_in;

      case (state_q)
        S_IDLE: begin
          // The count gate reserves a slot for the response before issuing,
          // so a push can never find the queue full.
          if (bus.pc_to_if_en_in && !bus.flush_in && (count_q < CNT_DEPTH)) begin
            mem_en_d   = 1'b1;
            mem_addr_d = bus.pc_in;
            req_pc_d   = bus.pc_in;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.flush_in) begin
            // A response arriving alongside the flush is dropped here;
            // otherwise it is still in flight and must be drained later.
            state_d = bus.mem_to_if_en_in ? S_IDLE : S_DRAIN;
          end else if (bus.mem_to_if_en_in) begin
            push    = 1'b1;
            pc_en_d = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_DRAIN: begin
          if (bus.mem_to_if_en_in) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Flush is ignored while draining; the queue is already empty then.
      if (bus.flush_in && (state_q != S_DRAIN)) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        if (push) tail_d = tail_q + PTR_ONE;
        if (pop)  head_d = head_q + PTR_ONE;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      req_pc_q   <= '0;
      pc_en_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      req_pc_q   <= req_pc_d;
      pc_en_q    <= pc_en_d;
    end
  end

  // Queue storage; the write lands at the edge, so the entry is only visible
  // to the decoder from the following cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_in && push) begin
      iq_instr_q[tail_q] <= bus.mem_to_if_instr_in;
      iq_pc_q[tail_q]    <= req_pc_q;
    end
  end

  assign bus.if_to_mem_en_out    = mem_en_q;
  assign bus.if_to_mem_addr_out  = mem_addr_q;
  assign bus.if_to_pc_en_out     = pc_en_q;
  assign bus.if_to_dec_en_out    = (count_q != '0);
  assign bus.if_to_dec_instr_out = iq_instr_q[head_q];
  assign bus.if_to_dec_pc_out    = iq_pc_q[head_q];
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, the address width.
REQ-002 SHALL have parameter INSTR_W, default 32, the instruction width.
REQ-003 SHALL have parameter IQ_DEPTH, default 4 (power of two), the instruction queue entries.
REQ-004 SHALL have port clk_in  input  1  single clock; all state updates on posedge.
REQ-005 SHALL have port rst_in  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port rdy_in  input  1  global ready; low freezes all state.
REQ-007 SHALL have port pc_to_if_en_in  input  1  pc_in is valid for fetch.
REQ-008 SHALL have port pc_in  input  ADDR_W  fetch address.
REQ-009 SHALL have port if_to_pc_en_out  output  1  one-cycle pulse telling the PC to advance by 4.
REQ-010 SHALL have port if_to_mem_en_out  output  1  memory fetch request valid.
REQ-011 SHALL have port if_to_mem_addr_out  output  ADDR_W  memory fetch address.
REQ-012 SHALL have port mem_to_if_en_in  input  1  memory returns an instruction this cycle.
REQ-013 SHALL have port mem_to_if_instr_in  input  INSTR_W  returned instruction.
REQ-014 SHALL have port flush_in  input  1  commit redirect; discard all fetched state.
REQ-015 SHALL have port if_to_dec_en_out  output  1  queue head valid to the decoder.
REQ-016 SHALL have port if_to_dec_instr_out  output  INSTR_W  queue head instruction.
REQ-017 SHALL have port if_to_dec_pc_out  output  ADDR_W  queue head PC.
REQ-018 SHALL have port dec_to_if_rdy_in  input  1  decoder accepts the head this cycle.

Function
REQ-019 SHALL implement FSM states IDLE, WAIT (one request outstanding) and DRAIN (discard the outstanding response).
REQ-020 SHALL, in IDLE with pc_to_if_en_in=1, flush_in=0 and queue count < IQ_DEPTH: register if_to_mem_en_out=1 and if_to_mem_addr_out=pc_in for exactly one cycle, latch pc_in as req_pc, and go to WAIT.
REQ-021 SHALL hold at most one outstanding memory request.
REQ-022 SHALL, in WAIT on mem_to_if_en_in=1 with flush_in=0: write {mem_to_if_instr_in, req_pc} at the tail, pulse if_to_pc_en_out=1 for one cycle, and return to IDLE.
REQ-023 SHALL make a queued entry visible on if_to_dec_* no earlier than the cycle after the write (no bypass).
REQ-024 SHALL drive if_to_dec_en_out = (count != 0) combinationally, with instr/pc taken from the head entry.
REQ-025 SHALL pop the head when if_to_dec_en_out & dec_to_if_rdy_in; outputs are unconstrained when en=0.
REQ-026 SHALL wrap head/tail pointers modulo IQ_DEPTH; count is log2(IQ_DEPTH)+1 bits wide, range 0..IQ_DEPTH.
REQ-027 SHALL support a same-cycle push and pop: count unchanged and both pointers advance.
REQ-028 SHALL never overflow: the issue gate in REQ-020 guarantees a free slot for every response.
REQ-029 SHALL, on flush_in=1: clear count and pointers, suppress if_to_pc_en_out and any new request that cycle, and go to DRAIN if in WAIT without a same-cycle response, else to IDLE.
REQ-030 SHALL, in DRAIN: ignore flush_in, discard the next mem_to_if_en_in response without a queue write or PC pulse, then go to IDLE.
REQ-031 SHALL flush with priority over a same-cycle push; a same-cycle pop is irrelevant.
REQ-032 SHALL, with rdy_in=0: hold all registers, deassert the pulse outputs if_to_mem_en_out and if_to_pc_en_out, and ignore all inputs; the memory side shares rdy_in.

Reset
REQ-033 SHALL, on rst_in=1 at posedge (regardless of rdy_in): enter IDLE, set count/head/tail=0, if_to_mem_en_out=0, if_to_pc_en_out=0, if_to_mem_addr_out=0, req_pc=0.
REQ-034 SHALL abandon any request outstanding at reset; the bench resets memory concurrently.
REQ-035 SHALL keep if_to_dec_en_out=0 from the first cycle after reset until the first push.

Verification
REQ-036 SHALL pass basic fetch: pc_in=0x0 valid, memory returns 0x00500093 two cycles later -> one mem request at addr 0x0, one if_to_pc_en_out pulse, next cycle dec outputs en=1, instr=0x00500093, pc=0x0.
REQ-037 SHALL pass full queue: dec_to_if_rdy_in=0, PC streams 0x0,0x4,... -> exactly 4 requests, count=4, no 5th request until one pop, then a request at 0x10.
REQ-038 SHALL pass flush in WAIT: request 0x8 outstanding, flush_in=1, PC redirected to 0x100 -> response for 0x8 discarded (no push, no pulse), next request addr 0x100.
REQ-039 SHALL pass simultaneous push/pop: count=2, response arrives while decoder pops -> count stays 2, FIFO order preserved.
REQ-040 SHALL pass rdy_in stall: rdy_in=0 for 3 cycles mid-WAIT -> no state/queue change, no pulses; behaviour resumes identically.
REQ-041 SHALL pass reset mid-operation: rst_in=1 with 3 entries and a request outstanding -> next cycle count=0, en=0, IDLE, all outputs 0.
